ddr_tile_reader: RTL and testbench
==================================

Name: ddr_tile_reader

Overview:
- Parametrised successor to the single-beat DDR3 row loader.
- Fetches a 2-D tile of ROWS x COLS 128-bit beats from DDR3 over the Avalon-MM port, with a programmable row pitch and up to MAX_OUTSTANDING pipelined reads in flight.
- Optional 1-beat zero border (padding) on all four sides of the tile.
- Stores the tile in an on-chip dual-port RAM that the compute array reads through a 1-cycle-latency read port.

Parameters:
- DATA_W, 128, Avalon data width and RAM word width
- ADDR_W, 26, Avalon word address width
- MAX_COLS, 64, maximum beats per tile row
- MAX_ROWS, 64, maximum tile rows
- MAX_OUTSTANDING, 8, maximum accepted-but-unreturned reads
- BUF_COLS (derived), MAX_COLS+2, RAM row pitch including the pad columns
- BUF_DEPTH (derived), (MAX_ROWS+2)*BUF_COLS, RAM depth in words

Ports:
- iCLK, in, 1, single clock
- iRST_N, in, 1, asynchronous active-low reset
- start, in, 1, 1-cycle request to load a tile; sampled only while not busy
- pad, in, 1, 1 = zero border, data placed at (r+1,c+1)
- start_address, in, ADDR_W, DDR word address of tile beat (0,0)
- stride, in, ADDR_W, DDR address increment between tile rows, in beats
- cols, in, 10, beats per row (1..MAX_COLS)
- rows, in, 10, row count (1..MAX_ROWS)
- busy, out, 1, high from accepted start until done
- done, out, 1, high when idle and after completion; low while busy
- cfg_err, out, 1, sticky: illegal config or unsolicited readdatavalid; cleared on next accepted start
- avl_address, out, ADDR_W, read address
- avl_read, out, 1, read request
- avl_burstbegin, out, 1, equals avl_read (single-beat bursts)
- avl_wait_request_n, in, 1, high = controller accepts the request this cycle
- avl_readdatavalid, in, 1, read data valid
- avl_readdata, in, DATA_W, read data
- rd_addr, in, $clog2(BUF_DEPTH), consumer RAM address
- rd_data, out, DATA_W, RAM word at rd_addr, registered, 1-cycle latency

Behaviour:
- Reset values: busy=0, done=1, cfg_err=0, avl_read=0, avl_address=0, state=IDLE, all counters 0.
- Reset is asynchronous. Asserting iRST_N low mid-operation drops avl_read immediately. RAM contents are not reset. Reads still in flight that return after reset are ignored; they do not set cfg_err, because the outstanding counter is 0 and the block is in IDLE.
- States and transitions:
  - IDLE: on start, latch all config inputs, set busy=1, done=0, clear cfg_err.
    - If cols=0, rows=0, cols>MAX_COLS or rows>MAX_ROWS: set cfg_err=1 and go to FINISH.
    - Else if pad=1: go to CLEAR.
    - Else: go to ISSUE.
  - CLEAR: write 0 to RAM words 0..BUF_DEPTH-1, one per cycle, then go to ISSUE. Takes exactly BUF_DEPTH cycles.
  - ISSUE: avl_read=1 whenever outstanding<MAX_OUTSTANDING and not all reads have been issued.
    - A request is accepted in a cycle where avl_read && avl_wait_request_n. While it is not accepted, avl_read and avl_address are held stable.
    - On accept, the issue column advances; on column wrap (col=cols-1) the column resets to 0, the row advances, and the row base address += stride.
    - avl_address = row_base + col, modulo 2^ADDR_W.
    - After the last accept, go to DRAIN.
  - DRAIN: avl_read=0. Wait for outstanding=0 and all responses written, then go to FINISH.
  - FINISH: busy=0, done=1, then go to IDLE in the same cycle.
- Outstanding counter:
  - +1 on accept, -1 on readdatavalid; no change when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
- Responses return in order and are tracked by a separate response row/column counter.
  - RAM write address = (r+pad)*BUF_COLS + (c+pad).
  - The write occurs in the readdatavalid cycle.
- readdatavalid with outstanding=0: the data is dropped and cfg_err is set to 1.
- start while busy is ignored.
- Latency:
  - pad=0: first avl_read is asserted the cycle after the start cycle.
  - done rises the cycle after the last response is written.
- Throughput: with wait_request_n held high and read latency L <= MAX_OUTSTANDING, one read is issued per cycle.
- Consumer port:
  - Readable at any time; contents are only defined while done=1.
  - RAM write/read collision on the same address returns old data.

Decomposition:
- Package ddr_rd_pkg: state enum (IDLE, CLEAR, ISSUE, DRAIN, FINISH), DATA_W/ADDR_W defaults, buf_index() address function.
- Sub-module tile_ram: simple dual-port RAM (1 write, 1 registered read), inferable to M10K, parameters DATA_W/BUF_DEPTH.

Test Plan:
- pad=0, start_address=0x100, stride=0x40, cols=4, rows=3, model latency 5, wait_request_n=1:
  - Required: 12 reads at 0x100..0x103, 0x140..0x143, 0x180..0x183.
  - RAM[r*66+c] = data tag(r,c).
  - done rises after the 12th response.
- Same as above with pad=1:
  - Required: CLEAR lasts 66*66 cycles.
  - Data appears at RAM[(r+1)*66+c+1]; RAM[0], RAM[65] and row 4 are all 0.
- wait_request_n toggling pseudo-randomly, model latency 20, MAX_OUTSTANDING=8:
  - Required: outstanding never exceeds 8.
  - avl_address and avl_read are held stable while not accepted.
  - Data is correct.
- Accept and readdatavalid in the same cycle, repeated for 50 cycles:
  - Required: outstanding stays constant.
  - Final count is 0 at done.
- cols=0 or rows=65:
  - Required: no avl_read; cfg_err=1; done returns 2 cycles after start.
  - Next valid start clears cfg_err.
- Assert iRST_N low with 5 reads outstanding, release it, then inject 5 late readdatavalid beats:
  - Required: avl_read=0 immediately; state=IDLE; done=1.
  - Late beats are not written to RAM.
- Start pulsed while busy:
  - Required: the pulse is ignored and the running transfer is unaffected.

Source files
------------

// File: rtl/ddr_rd_pkg.sv
// Shared types and helpers for the DDR tile reader.
// Holds the controller state encoding and the tile-buffer addressing rule.
package ddr_rd_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int ADDR_W_DEF = 26;

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, FINISH} state_e;

  // Buffer word for tile beat (r,c); padding shifts data one row and one column in.
  function automatic int unsigned buf_index(input int unsigned r, input int unsigned c,
                                            input logic pad, input int unsigned pitch);
    int unsigned p;
    p = pad ? 32'd1 : 32'd0;
    return (r + p) * pitch + c + p;
  endfunction

endpackage

// File: rtl/tile_ram.sv
// Simple dual-port tile buffer: one write port, one registered read port.
// A read of the word being written in the same cycle returns the old contents.
module tile_ram #(
  parameter int DATA_W    = 128,
  parameter int BUF_DEPTH = 4356,
  parameter int AW        = $clog2(BUF_DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ddr_tile_reader.sv
// Fetches a ROWS x COLS tile of beats from DDR over Avalon-MM into the tile buffer,
// with pipelined single-beat reads and an optional zero border.
//
// state  | meaning
// IDLE   | waiting for start, config inputs sampled here
// CLEAR  | zeroing every buffer word before a padded load
// ISSUE  | issuing reads, bounded by the outstanding window
// DRAIN  | all reads issued, collecting the remaining responses
// FINISH | one-cycle completion, back to IDLE
module ddr_tile_reader
  import ddr_rd_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int MAX_COLS        = 64,
  parameter int MAX_ROWS        = 64,
  parameter int MAX_OUTSTANDING = 8,
  localparam int BUF_COLS  = MAX_COLS + 2,
  localparam int BUF_DEPTH = (MAX_ROWS + 2) * BUF_COLS,
  localparam int RA_W      = $clog2(BUF_DEPTH)
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              start,
  input  logic              pad,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [ADDR_W-1:0] stride,
  input  logic [9:0]        cols,
  input  logic [9:0]        rows,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [ADDR_W-1:0] avl_address,
  output logic              avl_read,
  output logic              avl_burstbegin,
  input  logic              avl_wait_request_n,
  input  logic              avl_readdatavalid,
  input  logic [DATA_W-1:0] avl_readdata,
  input  logic [RA_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  state_e            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, pad_q, pad_d;
  logic [ADDR_W-1:0] stride_q, stride_d, base_q, base_d;
  logic [9:0]        cols_q, cols_d, rows_q, rows_d;
  logic [9:0]        icol_q, icol_d, irow_q, irow_d, rcol_q, rcol_d, rrow_q, rrow_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [RA_W-1:0]   clr_q, clr_d;
  logic              accept, rsp, bad_cfg;
  logic              ram_we;
  logic [RA_W-1:0]   ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign avl_read       = (state_q == ISSUE) && (out_q < OUT_W'(MAX_OUTSTANDING));
  assign avl_burstbegin = avl_read;
  assign avl_address    = base_q + ADDR_W'(icol_q);
  assign accept         = avl_read && avl_wait_request_n;
  // A beat with nothing outstanding is unsolicited and never reaches the buffer.
  assign rsp            = avl_readdatavalid && (out_q != '0);
  assign bad_cfg        = (cols == 10'd0) || (rows == 10'd0) ||
                          (cols > 10'(MAX_COLS)) || (rows > 10'(MAX_ROWS));
  assign busy           = busy_q;
  assign done           = done_q;
  assign cfg_err        = err_q;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    pad_d    = pad_q;
    stride_d = stride_q;
    base_d   = base_q;
    cols_d   = cols_q;
    rows_d   = rows_q;
    icol_d   = icol_q;
    irow_d   = irow_q;
    rcol_d   = rcol_q;
    rrow_d   = rrow_q;
    out_d    = out_q;
    clr_d    = clr_q;

    case ({accept, rsp})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    if (rsp) begin
      if (rcol_q == cols_q - 10'd1) begin
        rcol_d = '0;
        rrow_d = rrow_q + 1'b1;
      end else begin
        rcol_d = rcol_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: if (start) begin
        pad_d    = pad;
        stride_d = stride;
        base_d   = start_address;
        cols_d   = cols;
        rows_d   = rows;
        icol_d   = '0;
        irow_d   = '0;
        rcol_d   = '0;
        rrow_d   = '0;
        clr_d    = '0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (bad_cfg) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (pad) begin
          state_d = CLEAR;
        end else begin
          state_d = ISSUE;
        end
      end
      CLEAR: begin
        if (clr_q == RA_W'(BUF_DEPTH - 1)) begin
          clr_d   = '0;
          state_d = ISSUE;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      ISSUE: if (accept) begin
        if (icol_q == cols_q - 10'd1) begin
          icol_d = '0;
          irow_d = irow_q + 1'b1;
          base_d = base_q + stride_q;
          if (irow_q == rows_q - 10'd1) state_d = DRAIN;
        end else begin
          icol_d = icol_q + 1'b1;
        end
      end
      // Completion is flagged together with the final write so done lags it by one cycle.
      DRAIN: if (out_d == '0) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = FINISH;
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (avl_readdatavalid && (out_q == '0) && (state_q != IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b1;
      err_q    <= 1'b0;
      pad_q    <= 1'b0;
      stride_q <= '0;
      base_q   <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      icol_q   <= '0;
      irow_q   <= '0;
      rcol_q   <= '0;
      rrow_q   <= '0;
      out_q    <= '0;
      clr_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      pad_q    <= pad_d;
      stride_q <= stride_d;
      base_q   <= base_d;
      cols_q   <= cols_d;
      rows_q   <= rows_d;
      icol_q   <= icol_d;
      irow_q   <= irow_d;
      rcol_q   <= rcol_d;
      rrow_q   <= rrow_d;
      out_q    <= out_d;
      clr_q    <= clr_d;
    end
  end

  assign ram_we    = (state_q == CLEAR) || rsp;
  assign ram_waddr = (state_q == CLEAR) ? clr_q
                   : RA_W'(buf_index(32'(rrow_q), 32'(rcol_q), pad_q, BUF_COLS));
  assign ram_wdata = (state_q == CLEAR) ? '0 : avl_readdata;

  tile_ram #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH),
    .AW        (RA_W)
  ) u_ram (
    .clk_i   (iCLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_ddr_tile_reader.sv
// Bench for ddr_tile_reader: an Avalon read slave with fixed latency and optional
// random wait-request, plus a tile model computing expected addresses and buffer contents.
module tb_ddr_tile_reader;
  import ddr_rd_pkg::*;

  localparam int BC = 66;

  logic         iCLK, iRST_N, start, pad;
  logic [25:0]  start_address, stride;
  logic [9:0]   cols, rows;
  logic         busy, done, cfg_err;
  logic [25:0]  avl_address;
  logic         avl_read, avl_burstbegin, avl_wait_request_n, avl_readdatavalid;
  logic [127:0] avl_readdata, rd_data;
  logic [12:0]  rd_addr;

  ddr_tile_reader dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .start(start), .pad(pad),
    .start_address(start_address), .stride(stride), .cols(cols), .rows(rows),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .avl_address(avl_address), .avl_read(avl_read), .avl_burstbegin(avl_burstbegin),
    .avl_wait_request_n(avl_wait_request_n), .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata(avl_readdata), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_pass = 0, n_total = 0;

  typedef struct {int due; logic [25:0] addr;} rsp_t;
  rsp_t        pend[$];
  logic [25:0] acc_addrs[$];
  int cyc = 0, lat = 5, acc_budget = -1, n_acc = 0, n_ret = 0;
  int max_out = 0, n_both = 0, n_unstable = 0, n_read_cyc = 0, n_burst_bad = 0;
  int first_acc = -1, last_acc = -1, last_rdv_cyc = 0, done_rise_cyc = 0;
  bit rand_wr = 0;

  function automatic logic [127:0] tag(input logic [25:0] a);
    logic [31:0] x;
    x = {6'd0, a};
    return {x * 32'd3 + 32'd1, ~x, x ^ 32'h5A5A_5A5A, x};
  endfunction

  // Avalon slave: in-order responses returned lat cycles after acceptance.
  initial begin : slave
    bit prev_pend, done_prev, w, rv, acc;
    logic [25:0] prev_addr;
    prev_pend = 0; done_prev = 1; prev_addr = '0;
    avl_wait_request_n = 1'b1; avl_readdatavalid = 1'b0; avl_readdata = '0;
    forever begin
      @(negedge iCLK);
      cyc++;
      if (done && !done_prev) done_rise_cyc = cyc;
      done_prev = done;
      if (iRST_N && prev_pend && (!avl_read || avl_address !== prev_addr)) n_unstable++;
      if (avl_burstbegin !== avl_read) n_burst_bad++;
      w = rand_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (acc_budget == 0) w = 0;
      avl_wait_request_n = w;
      rv = 0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rv = 1;
        avl_readdata = tag(pend[0].addr);
        void'(pend.pop_front());
        n_ret++;
        last_rdv_cyc = cyc;
      end
      avl_readdatavalid = rv;
      acc = iRST_N && avl_read && w;
      if (acc) begin
        pend.push_back('{cyc + lat, avl_address});
        acc_addrs.push_back(avl_address);
        n_acc++;
        if (acc_budget > 0) acc_budget--;
        if (rv) n_both++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (n_acc - n_ret > max_out) max_out = n_acc - n_ret;
      if (avl_read) n_read_cyc++;
      prev_pend = avl_read && !w;
      prev_addr = avl_address;
    end
  end

  task automatic clear_mon();
    acc_addrs.delete();
    max_out = 0; n_both = 0; n_unstable = 0; n_read_cyc = 0; n_burst_bad = 0;
    first_acc = -1; last_acc = -1;
  endtask

  task automatic read_ram(input int a, output logic [127:0] d);
    @(negedge iCLK);
    rd_addr = 13'(a);
    @(negedge iCLK);
    d = rd_data;
  endtask

  // Starts a tile and waits for done; optionally re-pulses start with another config mid-run.
  task automatic run_tile(input logic p, input logic [25:0] sa, input logic [25:0] st,
                          input logic [9:0] c, input logic [9:0] r, input int pulse_at,
                          output int first_rd, output bit to);
    @(negedge iCLK);
    pad = p; start_address = sa; stride = st; cols = c; rows = r; start = 1'b1;
    @(negedge iCLK);
    start = 1'b0; first_rd = -1; to = 1;
    for (int k = 1; k < 20000; k++) begin
      if (avl_read && first_rd < 0) first_rd = k;
      if (done) begin to = 0; break; end
      if (k == pulse_at) begin
        start = 1'b1; pad = 1'b1; start_address = 26'h0; cols = 10'd2; rows = 10'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge iCLK);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL reset_done: got %b want 1", done); else n_pass++;
    n_total++; if (cfg_err !== 1'b0) $display("FAIL reset_err: got %b want 0", cfg_err); else n_pass++;
    n_total++; if (avl_read !== 1'b0) $display("FAIL reset_read: got %b want 0", avl_read); else n_pass++;
    n_total++; if (avl_address !== 26'h0) $display("FAIL reset_addr: got %h want 0", avl_address); else n_pass++;
  endtask

  task automatic test_tile_nopad();
    int fr; bit to; logic [127:0] d; int i;
    lat = 5; rand_wr = 0; clear_mon();
    run_tile(1'b0, 26'h100, 26'h40, 10'd4, 10'd3, -1, fr, to);
    n_total++; if (to) $display("FAIL nopad_timeout: done not seen"); else n_pass++;
    n_total++; if (fr !== 1) $display("FAIL nopad_first_read: got %0d want 1", fr); else n_pass++;
    n_total++; if (acc_addrs.size() !== 12) $display("FAIL nopad_nreads: got %0d want 12", acc_addrs.size()); else n_pass++;
    i = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        if (i < acc_addrs.size()) begin
          n_total++;
          if (acc_addrs[i] !== 26'(32'h100 + r * 32'h40 + c))
            $display("FAIL nopad_addr[%0d]: got %h want %h", i, acc_addrs[i], 32'h100 + r * 32'h40 + c);
          else n_pass++;
        end
        i++;
      end
    n_total++; if (done_rise_cyc - last_rdv_cyc !== 1)
      $display("FAIL nopad_done_lag: got %0d want 1", done_rise_cyc - last_rdv_cyc); else n_pass++;
    n_total++; if (n_burst_bad !== 0) $display("FAIL burstbegin: got %0d mismatching cycles want 0", n_burst_bad); else n_pass++;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        read_ram(r * BC + c, d);
        n_total++;
        if (d !== tag(26'(32'h100 + r * 32'h40 + c))) $display("FAIL nopad_data[%0d,%0d]: got %h", r, c, d);
        else n_pass++;
      end
  endtask

  task automatic test_tile_pad();
    int fr; bit to; logic [127:0] d; int nz;
    lat = 5; rand_wr = 0; clear_mon();
    run_tile(1'b1, 26'h100, 26'h40, 10'd4, 10'd3, -1, fr, to);
    n_total++; if (to) $display("FAIL pad_timeout: done not seen"); else n_pass++;
    n_total++; if (fr !== BC * BC + 1) $display("FAIL pad_clear_len: first read at %0d want %0d", fr, BC * BC + 1); else n_pass++;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        read_ram((r + 1) * BC + c + 1, d);
        n_total++;
        if (d !== tag(26'(32'h100 + r * 32'h40 + c))) $display("FAIL pad_data[%0d,%0d]: got %h", r, c, d);
        else n_pass++;
      end
    read_ram(0, d);
    n_total++; if (d !== '0) $display("FAIL pad_ram0: got %h want 0", d); else n_pass++;
    read_ram(65, d);
    n_total++; if (d !== '0) $display("FAIL pad_ram65: got %h want 0", d); else n_pass++;
    nz = 0;
    for (int c = 0; c < BC; c++) begin read_ram(4 * BC + c, d); if (d !== '0) nz++; end
    for (int r = 1; r < 4; r++) begin
      read_ram(r * BC, d); if (d !== '0) nz++;
      read_ram(r * BC + 5, d); if (d !== '0) nz++;
    end
    n_total++; if (nz !== 0) $display("FAIL pad_border: %0d nonzero words want 0", nz); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int fr; bit to; logic [127:0] d; logic [25:0] sa;
    lat = 5; rand_wr = 0; clear_mon();
    sa = 26'($urandom);
    run_tile(1'b0, sa, 26'h80, 10'd64, 10'd1, -1, fr, to);
    n_total++; if (to) $display("FAIL b2b_timeout: done not seen"); else n_pass++;
    n_total++; if (last_acc - first_acc !== 63) $display("FAIL b2b_rate: span %0d want 63", last_acc - first_acc); else n_pass++;
    n_total++; if (max_out !== 5) $display("FAIL b2b_outstanding: max %0d want 5", max_out); else n_pass++;
    n_total++; if (n_both < 50) $display("FAIL b2b_overlap: got %0d cycles want >=50", n_both); else n_pass++;
    n_total++; if (dut.out_q !== '0) $display("FAIL b2b_final_count: got %0d want 0", dut.out_q); else n_pass++;
    read_ram(63, d);
    n_total++; if (d !== tag(sa + 26'd63)) $display("FAIL b2b_data63: got %h", d); else n_pass++;
  endtask

  task automatic test_random_waitreq();
    int fr; bit to; logic [127:0] d; int bad, nc, nr, i;
    logic [25:0] sa, st; logic p;
    for (int it = 0; it < 2; it++) begin
      lat = 20; rand_wr = 1; clear_mon();
      sa = 26'($urandom); st = 26'($urandom);
      nc = $urandom_range(3, 12); nr = $urandom_range(2, 6); p = 1'($urandom_range(0, 1));
      run_tile(p, sa, st, 10'(nc), 10'(nr), -1, fr, to);
      rand_wr = 0;
      n_total++; if (to) $display("FAIL rnd_timeout[%0d]: done not seen", it); else n_pass++;
      n_total++; if (max_out > 8) $display("FAIL rnd_outstanding[%0d]: max %0d want <=8", it, max_out); else n_pass++;
      n_total++; if (n_unstable !== 0) $display("FAIL rnd_hold[%0d]: %0d unstable cycles want 0", it, n_unstable); else n_pass++;
      n_total++; if (acc_addrs.size() !== nc * nr)
        $display("FAIL rnd_nreads[%0d]: got %0d want %0d", it, acc_addrs.size(), nc * nr); else n_pass++;
      bad = 0; i = 0;
      for (int r = 0; r < nr; r++)
        for (int c = 0; c < nc; c++) begin
          if (i >= acc_addrs.size() || acc_addrs[i] !== sa + 26'(r) * st + 26'(c)) bad++;
          read_ram((r + int'(p)) * BC + c + int'(p), d);
          if (d !== tag(sa + 26'(r) * st + 26'(c))) bad++;
          i++;
        end
      n_total++; if (bad !== 0) $display("FAIL rnd_data[%0d]: %0d wrong addr/data want 0", it, bad); else n_pass++;
    end
  endtask

  task automatic test_cfg_err();
    int fr; bit to;
    logic [9:0] bc[3] = '{10'd0, 10'd4, 10'd65};
    logic [9:0] br[3] = '{10'd3, 10'd65, 10'd1};
    for (int t = 0; t < 3; t++) begin
      clear_mon();
      @(negedge iCLK);
      pad = 1'b0; start_address = 26'h10; stride = 26'h10; cols = bc[t]; rows = br[t]; start = 1'b1;
      @(negedge iCLK);
      start = 1'b0;
      n_total++; if (done !== 1'b0 || cfg_err !== 1'b1)
        $display("FAIL err_flag[%0d]: done=%b err=%b want done=0 err=1", t, done, cfg_err); else n_pass++;
      @(negedge iCLK);
      n_total++; if (done !== 1'b1) $display("FAIL err_done[%0d]: got %b want 1 two cycles after start", t, done); else n_pass++;
      repeat (3) @(negedge iCLK);
      n_total++; if (n_read_cyc !== 0) $display("FAIL err_reads[%0d]: got %0d read cycles want 0", t, n_read_cyc); else n_pass++;
    end
    lat = 3;
    run_tile(1'b0, 26'h40, 26'h10, 10'd2, 10'd2, -1, fr, to);
    n_total++; if (to || cfg_err !== 1'b0) $display("FAIL err_clear: timeout=%b err=%b want 0/0", to, cfg_err); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int fr; bit to; logic [127:0] d; int bad, i;
    lat = 5; rand_wr = 0; clear_mon();
    run_tile(1'b0, 26'h2000, 26'h100, 10'd5, 10'd3, 4, fr, to);
    n_total++; if (to) $display("FAIL busy_timeout: done not seen"); else n_pass++;
    n_total++; if (acc_addrs.size() !== 15) $display("FAIL busy_nreads: got %0d want 15", acc_addrs.size()); else n_pass++;
    bad = 0; i = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) begin
        if (i >= acc_addrs.size() || acc_addrs[i] !== 26'(32'h2000 + r * 32'h100 + c)) bad++;
        read_ram(r * BC + c, d);
        if (d !== tag(26'(32'h2000 + r * 32'h100 + c))) bad++;
        i++;
      end
    n_total++; if (bad !== 0) $display("FAIL busy_data: %0d wrong addr/data want 0", bad); else n_pass++;
    repeat (3) @(negedge iCLK);
    n_total++; if (busy !== 1'b0) $display("FAIL busy_restart: got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int fr, base, k; bit to; logic [127:0] d; int bad;
    lat = 20; rand_wr = 0; clear_mon();
    run_tile(1'b0, 26'h200, 26'h40, 10'd8, 10'd1, -1, fr, to);
    n_total++; if (to) $display("FAIL rst_pre_timeout: done not seen"); else n_pass++;
    base = n_acc; acc_budget = 5;
    @(negedge iCLK);
    pad = 1'b0; start_address = 26'h3000; stride = 26'h40; cols = 10'd8; rows = 10'd1; start = 1'b1;
    @(negedge iCLK);
    start = 1'b0;
    for (k = 0; k < 50 && n_acc < base + 5; k++) @(negedge iCLK);
    repeat (2) @(negedge iCLK);
    n_total++; if (avl_read !== 1'b1 || n_acc - base !== 5)
      $display("FAIL rst_setup: read=%b accepted=%0d want 1/5", avl_read, n_acc - base); else n_pass++;
    iRST_N = 1'b0;
    #1;
    n_total++; if (avl_read !== 1'b0) $display("FAIL rst_read_drop: got %b want 0", avl_read); else n_pass++;
    n_total++; if (dut.state_q !== IDLE || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_state: state=%0d done=%b busy=%b want IDLE/1/0", dut.state_q, done, busy); else n_pass++;
    @(negedge iCLK);
    iRST_N = 1'b1; acc_budget = -1;
    for (k = 0; k < 100 && pend.size() > 0; k++) @(negedge iCLK);
    repeat (3) @(negedge iCLK);
    n_total++; if (pend.size() !== 0 || cfg_err !== 1'b0)
      $display("FAIL rst_late_err: pending=%0d err=%b want 0/0", pend.size(), cfg_err); else n_pass++;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      read_ram(c, d);
      if (d !== tag(26'h200 + 26'(c))) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL rst_late_write: %0d words overwritten want 0", bad); else n_pass++;
  endtask

  initial begin
    iRST_N = 1'b0; start = 1'b0; pad = 1'b0; start_address = '0; stride = '0;
    cols = '0; rows = '0; rd_addr = '0;
    repeat (3) @(negedge iCLK);
    test_reset();
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);
    test_tile_nopad();
    test_tile_pad();
    test_back_to_back();
    test_random_waitreq();
    test_cfg_err();
    test_start_while_busy();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
